// File: rtl/hilo_div_ctrl_if.sv
// Bus between the HI/LO sequencer and the iterative divider.
// The sequencer drives the master side and the divider drives the slave side.
interface hilo_div_ctrl_if;
  logic [31:0] DivA;
  logic [31:0] DivB;
  logic        DivCtrl;
  logic        DivRst;
  logic        DivDoneIn;
  logic        Div0In;
  logic [31:0] QuotIn;
  logic [31:0] RemIn;

  modport master (
    output DivA, DivB, DivCtrl, DivRst,
    input  DivDoneIn, Div0In, QuotIn, RemIn
  );

  modport slave (
    input  DivA, DivB, DivCtrl, DivRst,
    output DivDoneIn, Div0In, QuotIn, RemIn
  );
endinterface

// File: rtl/hilo_div_ctrl.sv
// HI/LO sequencer: latches div operands, starts the divider, and commits the
// remainder/quotient to HI/LO. It also serves mthi/mtlo writes while idle.
module hilo_div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [31:0]           FromA,
  input  logic [31:0]           FromB,
  input  logic                  WrHI,
  input  logic                  WrLO,
  input  logic [31:0]           WrData,
  hilo_div_ctrl_if.master       div,
  output logic [31:0]           HIOut,
  output logic [31:0]           LOOut,
  output logic                  Busy,
  output logic                  Done,
  output logic                  DivZeroExc,
  output logic                  DivTimeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  state_t      state_r;
  logic [31:0] cnt_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic [31:0] div_a_r;
  logic [31:0] div_b_r;
  logic        div_ctrl_r;
  logic        div_rst_r;
  logic        busy_r;
  logic        done_r;
  logic        zero_exc_r;
  logic        timeout_r;

  // Sequencer FSM; every output is a register updated together with the state.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= S_IDLE;
      cnt_r      <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      div_a_r    <= 32'd0;
      div_b_r    <= 32'd0;
      div_ctrl_r <= 1'b0;
      div_rst_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      zero_exc_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      div_ctrl_r <= 1'b0;
      div_rst_r  <= 1'b0;
      done_r     <= 1'b0;
      zero_exc_r <= 1'b0;
      timeout_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (WrHI) hi_r <= WrData;
          if (WrLO) lo_r <= WrData;
          // A zero divisor is trapped here so the divider never sees it.
          if (Start && (FromB != 32'd0)) begin
            div_a_r    <= FromA;
            div_b_r    <= FromB;
            cnt_r      <= 32'd0;
            div_ctrl_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= S_ISSUE;
          end else if (Start) begin
            zero_exc_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (div.Div0In) begin
            zero_exc_r <= 1'b1;
            div_rst_r  <= 1'b1;
            state_r    <= S_ABORT;
          end else if (div.DivDoneIn) begin
            hi_r    <= div.RemIn;
            lo_r    <= div.QuotIn;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if ((TIMEOUT_CYCLES != 32'd0) && (cnt_r == TIMEOUT_LAST)) begin
            timeout_r <= 1'b1;
            div_rst_r <= 1'b1;
            state_r   <= S_ABORT;
          end else begin
            cnt_r <= cnt_r + 32'd1;
          end
        end
        S_ABORT: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign div.DivA    = div_a_r;
  assign div.DivB    = div_b_r;
  assign div.DivCtrl = div_ctrl_r;
  assign div.DivRst  = div_rst_r;
  assign HIOut       = hi_r;
  assign LOOut       = lo_r;
  assign Busy        = busy_r;
  assign Done        = done_r;
  assign DivZeroExc  = zero_exc_r;
  assign DivTimeout  = timeout_r;

endmodule
